score_ram_reader: RTL

Traceback-side reader for the score RAM of the Needleman-Wunsch datapath. Given a matrix cell (i, j), it fetches the three neighbour scores (diagonal, up, left) from the score RAM with paced single-port reads. It returns them with a one-cycle done pulse and, optionally, the winning traceback direction. It is the read counterpart of the paced score-RAM write path and sits between the traceback controller and the score RAM port.

---
 rtl/nw_pkg.sv | 25 ++
 rtl/read_pace_counter.sv | 30 +++
 rtl/score_ram_reader.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/nw_pkg.sv
// Shared definitions for the Needleman-Wunsch score datapath:
// traceback direction codes, controller states and the score sentinel.
package nw_pkg;

  localparam logic [1:0] DIR_NONE = 2'b00;
  localparam logic [1:0] DIR_DIAG = 2'b01;
  localparam logic [1:0] DIR_UP   = 2'b10;
  localparam logic [1:0] DIR_LEFT = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_NEXT,
    ST_DONE
  } state_t;

  // Most negative two's-complement value of a w-bit score; take the low w bits.
  function automatic logic [31:0] SCORE_MIN(input int w);
    logic [31:0] allOnes;
    allOnes = '1;
    return allOnes << (w - 1);
  endfunction

endpackage

// File: rtl/read_pace_counter.sv
// Paces a single-port RAM read: counts READ_WAIT enabled cycles after a clear
// and flags the final one with last.
module read_pace_counter #(
  parameter int READ_WAIT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic last
);

  localparam int CW = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(READ_WAIT - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (en && (r_count != LAST_CNT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign last = en && (r_count == LAST_CNT);

endmodule

// File: rtl/score_ram_reader.sv
// Traceback-side score RAM reader: fetches diag/up/left neighbour scores of a cell.
// Define SCORE_RAM_READER_DIR_EN to also produce the winning traceback direction.
module score_ram_reader
  import nw_pkg::*;
#(
  parameter int N         = 8,
  parameter int SCORE_W   = 8,
  parameter int IDX_W     = $clog2(N + 1),
  parameter int ADDR_W    = $clog2((N + 1) * (N + 1)),
  parameter int READ_WAIT = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [IDX_W-1:0]   i,
  input  logic [IDX_W-1:0]   j,
  output logic               ram_rd_en,
  output logic [ADDR_W-1:0]  ram_addr,
  input  logic [SCORE_W-1:0] ram_rd_data,
  output logic               busy,
  output logic               done,
  output logic [SCORE_W-1:0] score_diag,
  output logic [SCORE_W-1:0] score_up,
  output logic [SCORE_W-1:0] score_left,
  output logic [1:0]         dir
);

  localparam logic [31:0]        MIN32    = SCORE_MIN(SCORE_W);
  localparam logic [SCORE_W-1:0] SENTINEL = MIN32[SCORE_W-1:0];
  localparam logic [ADDR_W-1:0]  ROW_LEN  = ADDR_W'(N + 1);

  state_t             r_state, w_nextState;
  logic [IDX_W-1:0]   r_i, r_j;
  logic [1:0]         r_k, w_nextK;
  logic [SCORE_W-1:0] r_diag, r_up, r_left;
  logic [SCORE_W-1:0] w_nDiag, w_nUp, w_nLeft, w_loadVal;
  logic [IDX_W-1:0]   w_row, w_col;
  logic [ADDR_W-1:0]  w_addr;
  logic               w_inRange, w_load, w_advance, w_last, w_finish;

  // Neighbour k: 0 = (i-1, j-1), 1 = (i-1, j), 2 = (i, j-1).
  always_comb begin
    w_inRange = 1'b0;
    w_row     = r_i;
    w_col     = r_j;
    case (r_k)
      2'd0: begin
        w_inRange = (r_i != '0) && (r_j != '0);
        w_row     = r_i - 1'b1;
        w_col     = r_j - 1'b1;
      end
      2'd1: begin
        w_inRange = (r_i != '0);
        w_row     = r_i - 1'b1;
      end
      default: begin
        w_inRange = (r_j != '0);
        w_col     = r_j - 1'b1;
      end
    endcase
  end

  assign w_addr = ADDR_W'(w_row) * ROW_LEN + ADDR_W'(w_col);

  read_pace_counter #(
    .READ_WAIT(READ_WAIT)
  ) u_pace (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(r_state == ST_ISSUE),
    .en   (r_state == ST_WAIT),
    .last (w_last)
  );

  // NEXT never occupies a cycle: a finished or skipped fetch advances k directly.
  always_comb begin
    w_nextState = r_state;
    w_nextK     = r_k;
    w_load      = 1'b0;
    w_loadVal   = ram_rd_data;
    w_advance   = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_nextState = ST_ISSUE;
          w_nextK     = 2'd0;
        end
      end
      ST_ISSUE: begin
        if (w_inRange) begin
          w_nextState = ST_WAIT;
        end else begin
          w_load    = 1'b1;
          w_loadVal = SENTINEL;
          w_advance = 1'b1;
        end
      end
      ST_WAIT: begin
        if (w_last) begin
          w_load    = 1'b1;
          w_advance = 1'b1;
        end
      end
      ST_DONE: w_nextState = ST_IDLE;
      default: w_nextState = ST_IDLE;
    endcase
    if (w_advance) begin
      if (r_k != 2'd2) begin
        w_nextK     = r_k + 2'd1;
        w_nextState = ST_ISSUE;
      end else begin
        w_nextState = ST_DONE;
        w_finish    = 1'b1;
      end
    end
  end

  assign w_nDiag = (w_load && (r_k == 2'd0)) ? w_loadVal : r_diag;
  assign w_nUp   = (w_load && (r_k == 2'd1)) ? w_loadVal : r_up;
  assign w_nLeft = (w_load && (r_k == 2'd2)) ? w_loadVal : r_left;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_i     <= '0;
      r_j     <= '0;
      r_k     <= '0;
      r_diag  <= '0;
      r_up    <= '0;
      r_left  <= '0;
    end else begin
      r_state <= w_nextState;
      r_k     <= w_nextK;
      r_diag  <= w_nDiag;
      r_up    <= w_nUp;
      r_left  <= w_nLeft;
      if ((r_state == ST_IDLE) && start) begin
        r_i <= i;
        r_j <= j;
      end
    end
  end

`ifdef SCORE_RAM_READER_DIR_EN
  logic [1:0] r_dir, w_dir;
  logic       w_vDiag, w_vUp, w_vLeft;

  // Only in-range neighbours compete; ties resolve diag > up > left.
  always_comb begin
    w_vDiag = (r_i != '0) && (r_j != '0);
    w_vUp   = (r_i != '0);
    w_vLeft = (r_j != '0);
    w_dir   = DIR_NONE;
    if (w_vDiag && (!w_vUp || ($signed(w_nDiag) >= $signed(w_nUp)))
                && (!w_vLeft || ($signed(w_nDiag) >= $signed(w_nLeft)))) begin
      w_dir = DIR_DIAG;
    end else if (w_vUp && (!w_vLeft || ($signed(w_nUp) >= $signed(w_nLeft)))) begin
      w_dir = DIR_UP;
    end else if (w_vLeft) begin
      w_dir = DIR_LEFT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dir <= DIR_NONE;
    end else if (w_finish) begin
      r_dir <= w_dir;
    end
  end

  assign dir = r_dir;
`else
  assign dir = DIR_NONE;
`endif

  assign busy       = (r_state != ST_IDLE);
  assign done       = (r_state == ST_DONE);
  assign ram_rd_en  = (r_state == ST_ISSUE) && w_inRange;
  assign ram_addr   = (ram_rd_en || (r_state == ST_WAIT)) ? w_addr : '0;
  assign score_diag = r_diag;
  assign score_up   = r_up;
  assign score_left = r_left;

endmodule
